// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage
// Description : Pipeline fetch stage. Fetches the instruction at pc_i from a
//               variable-latency instruction memory (req/ack), stalls the PC
//               through pc_write_o while the fetch is outstanding, and loads
//               the IF/ID register (instruction, PC+4, valid) with support
//               for decode stalls and branch flushes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1   clock, rising edge
//   rst_i          in   1   asynchronous reset, active low
//   pc_i           in  32   current PC
//   pc_write_o     out  1   1 = PC holds, 0 = PC loads next value
//   imem_req_o     out  1   memory request
//   imem_addr_o    out 32   fetch address
//   imem_ack_i     in   1   one-cycle response strobe
//   imem_data_i    in  32   instruction word (valid with ack)
//   id_stall_i     in   1   decode hazard, IF/ID holds
//   flush_i        in   1   branch/jump taken, squash fetch and IF/ID
//   if_id_valid_o  out  1   IF/ID holds a real instruction
//   if_id_instr_o  out 32   IF/ID instruction
//   if_id_pc4_o    out 32   IF/ID PC+4
//   fetch_err_o    out  1   sticky ack-timeout flag
// ============================================================================
module instr_fetch_stage #(
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [7:0]  WAIT_LIMIT = 8'd15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pc_write_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        id_stall_i,
  input  logic        flush_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_addr;
  logic [31:0] hold_word;
  logic [7:0]  wait_cnt;
  logic [7:0]  cnt_nxt;
  logic        err_set;
  logic        load_addr;
  logic        save_word;
  logic        accept;
  logic [31:0] accept_word;
  logic        in_wait;

  assign imem_addr_o = req_addr;
  assign in_wait     = (state == S_FETCH) || (state == S_DRAIN);

  // --------------------------------------------------------------------------
  // Next-state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    pc_write_o  = 1'b1;
    imem_req_o  = 1'b0;
    load_addr   = 1'b0;
    save_word   = 1'b0;
    accept      = 1'b0;
    accept_word = imem_data_i;
    case (state)
      S_IDLE: begin
        if (flush_i) begin
          pc_write_o = 1'b0;
        end else begin
          load_addr = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (flush_i) begin
            pc_write_o = 1'b0;
            state_nxt  = S_IDLE;
          end else if (id_stall_i) begin
            // Decode cannot take the word yet: park it until the stall drops.
            save_word = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            accept     = 1'b1;
            pc_write_o = 1'b0;
            state_nxt  = S_IDLE;
          end
        end else if (flush_i) begin
          pc_write_o = 1'b0;
          state_nxt  = S_DRAIN;
        end
      end
      S_HOLD: begin
        accept_word = hold_word;
        if (flush_i) begin
          pc_write_o = 1'b0;
          state_nxt  = S_IDLE;
        end else if (!id_stall_i) begin
          accept     = 1'b1;
          pc_write_o = 1'b0;
          state_nxt  = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The squashed request stays on the bus until memory answers; each
        // flush seen here reloads the PC with the newest target.
        imem_req_o = 1'b1;
        pc_write_o = !flush_i;
        if (imem_ack_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Ack wait counter: restarts on each new request phase and on ack
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_nxt = wait_cnt;
    err_set = 1'b0;
    if (state == S_IDLE && state_nxt == S_FETCH) begin
      cnt_nxt = 8'd0;
    end else if (in_wait && imem_ack_i) begin
      cnt_nxt = 8'd0;
    end else if (state == S_FETCH && state_nxt == S_DRAIN) begin
      cnt_nxt = 8'd0;
    end else if (in_wait) begin
      if (wait_cnt != 8'hFF) begin
        cnt_nxt = wait_cnt + 8'd1;
      end
      err_set = (cnt_nxt >= WAIT_LIMIT);
    end
  end

  // --------------------------------------------------------------------------
  // State, request address, hold register, counter and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      req_addr    <= 32'd0;
      hold_word   <= 32'd0;
      wait_cnt    <= 8'd0;
      fetch_err_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      if (load_addr) begin
        req_addr <= pc_i;
      end
      if (save_word) begin
        hold_word <= imem_data_i;
      end
      if (err_set) begin
        fetch_err_o <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID register: flush > stall > accept > bubble
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
      if_id_pc4_o   <= 32'd0;
    end else if (flush_i) begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end else if (id_stall_i) begin
      if_id_valid_o <= if_id_valid_o;
    end else if (accept) begin
      if_id_valid_o <= 1'b1;
      if_id_instr_o <= accept_word;
      if_id_pc4_o   <= req_addr + 32'd4;
    end else begin
      if_id_valid_o <= 1'b0;
      if_id_instr_o <= NOP_INSTR;
    end
  end

endmodule
`default_nettype wire
